// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and constants for the 1-to-4 stream demultiplexer.
// Revision 1.0
`default_nettype none

package stream_demux_pkg;
  localparam int N_OUT = 4;
  typedef logic [1:0] sel_t;
  typedef logic [7:0] cnt_t;
endpackage

`default_nettype wire

// File: rtl/stream_slot.sv
// stream_slot: one-entry registered output slot with valid flag and transfer counter.
// Revision 1.0
`default_nettype none

module stream_slot
  import stream_demux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] data_in,
  output logic         valid,
  output logic [W-1:0] data_out,
  input  logic         ready,
  output cnt_t         count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      data_out <= '0;
      count    <= '0;
    end else begin
      // A load in the same cycle as a drain keeps the slot full with the new payload.
      if (load) begin
        valid    <= 1'b1;
        data_out <= data_in;
      end else if (ready) begin
        valid    <= 1'b0;
      end
      if (valid && ready) begin
        count <= count + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4: routes one valid/ready stream to one of four registered output slots.
// Revision 1.0
`default_nettype none

module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_valid,
  input  sel_t                 up_sel,
  input  logic [W-1:0]         up_data,
  output logic                 up_ready,
  output logic [N_OUT-1:0]     dn_valid,
  output logic [N_OUT*W-1:0]   dn_data,
  input  logic [N_OUT-1:0]     dn_ready,
  output logic [N_OUT*8-1:0]   dn_count
);

  logic [N_OUT-1:0] load;

  // Ready looks through a draining slot so one destination sustains full rate.
  assign up_ready = ~dn_valid[up_sel] | dn_ready[up_sel];

  always_comb begin
    load         = '0;
    load[up_sel] = up_valid & up_ready;
  end

  generate
    for (genvar i = 0; i < N_OUT; i++) begin : g_slot
      stream_slot #(.W(W)) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load[i]),
        .data_in  (up_data),
        .valid    (dn_valid[i]),
        .data_out (dn_data[i*W +: W]),
        .ready    (dn_ready[i]),
        .count    (dn_count[i*8 +: 8])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_1_4.sv
// tb_stream_demux_1_4: scoreboard bench with per-channel expected queues and a reference model.
// Revision 1.0
`default_nettype none

module tb_stream_demux_1_4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           up_valid = 1'b0;
  logic [1:0]     up_sel = 2'd0;
  logic [W-1:0]   up_data = '0;
  logic           up_ready;
  logic [3:0]     dn_valid;
  logic [4*W-1:0] dn_data;
  logic [3:0]     dn_ready = 4'b0;
  logic [31:0]    dn_count;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [W-1:0] exp_q[4][$];
  int unsigned exp_cnt[4];

  stream_demux_1_4 #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (up_valid),
    .up_sel   (up_sel),
    .up_data  (up_data),
    .up_ready (up_ready),
    .dn_valid (dn_valid),
    .dn_data  (dn_data),
    .dn_ready (dn_ready),
    .dn_count (dn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a slot is full exactly when its expected queue holds an entry.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("dn_valid[%0d]", i), 32'(dn_valid[i]), 32'(exp_q[i].size() != 0));
        check($sformatf("dn_count[%0d]", i), 32'(dn_count[i*8 +: 8]), exp_cnt[i] % 256);
        if (exp_q[i].size() != 0) begin
          check($sformatf("dn_data[%0d]", i), 32'(dn_data[i*W +: W]), 32'(exp_q[i][0]));
          if (dn_ready[i] && rst_n) begin
            void'(exp_q[i].pop_front());
            exp_cnt[i]++;
          end
        end
      end
    end
  end

  // One clock cycle of stimulus; the model records what the coming edge should do.
  task automatic cycle(input logic v, input logic [1:0] sel, input logic [W-1:0] d,
                       input logic [3:0] rdy, input logic rn);
    bit exp_rdy;
    up_valid = v;
    up_sel   = sel;
    up_data  = d;
    dn_ready = rdy;
    rst_n    = rn;
    #7;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[i].delete();
        exp_cnt[i] = 0;
      end
    end else if (up_valid) begin
      exp_rdy = (exp_q[sel].size() == 0) || dn_ready[sel];
      check("up_ready", 32'(up_ready), 32'(exp_rdy));
      if (exp_rdy) exp_q[sel].push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared();
    check("reset dn_valid", 32'(dn_valid), 32'h0);
    check("reset dn_data", 32'(dn_data), 32'h0);
    check("reset dn_count", dn_count, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    @(posedge clk);
    #1;

    // Reset then idle
    cycle(1'b0, 2'd0, '0, 4'h0, 1'b0);
    mon_en = 1'b1;
    cycle(1'b0, 2'd0, '0, 4'h0, 1'b0);
    check_cleared();
    for (int s = 0; s < 4; s++) begin
      cycle(1'b1, 2'(s), 4'hf, 4'h0, 1'b0);
      check("up_ready in reset", 32'(up_ready), 32'h1);
    end
    cycle(1'b0, 2'd0, '0, 4'h0, 1'b1);
    check_cleared();

    // Basic route
    cycle(1'b1, 2'd0, 4'ha, 4'hf, 1'b1);
    cycle(1'b1, 2'd1, 4'hb, 4'hf, 1'b1);
    cycle(1'b1, 2'd2, 4'hc, 4'hf, 1'b1);
    cycle(1'b1, 2'd3, 4'hd, 4'hf, 1'b1);
    cycle(1'b0, 2'd0, '0, 4'hf, 1'b1);
    cycle(1'b0, 2'd0, '0, 4'hf, 1'b1);
    check("basic counts", dn_count, 32'h01010101);

    // Stall isolation
    cycle(1'b1, 2'd2, 4'h5, 4'hb, 1'b1);
    cycle(1'b1, 2'd2, 4'h6, 4'hb, 1'b1);
    check("stalled slot data", 32'(dn_data[2*W +: W]), 32'h5);
    cycle(1'b1, 2'd0, 4'h7, 4'hb, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 2'd0, '0, 4'hb, 1'b1);
    check("slot 2 held", 32'(dn_data[2*W +: W]), 32'h5);
    cycle(1'b0, 2'd0, '0, 4'hf, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 2'd0, '0, 4'hf, 1'b1);
    check("slot 2 once", 32'(dn_count[2*8 +: 8]), 32'h2);

    // Full-rate same slot
    for (int k = 1; k <= 8; k++) cycle(1'b1, 2'd1, 4'(k), 4'h2, 1'b1);
    cycle(1'b0, 2'd0, '0, 4'h2, 1'b1);
    cycle(1'b0, 2'd0, '0, 4'h2, 1'b1);
    check("full-rate count", 32'(dn_count[1*8 +: 8]), 32'd9);

    // Counter wrap: slot 3 already carries one transfer
    for (int k = 0; k < 257; k++) cycle(1'b1, 2'd3, 4'($urandom), 4'h8, 1'b1);
    cycle(1'b0, 2'd0, '0, 4'h8, 1'b1);
    cycle(1'b0, 2'd0, '0, 4'h8, 1'b1);
    check("wrap count", 32'(dn_count[3*8 +: 8]), 32'd2);

    // Reset mid-operation
    cycle(1'b1, 2'd0, 4'h9, 4'h0, 1'b1);
    cycle(1'b1, 2'd3, 4'h3, 4'h0, 1'b1);
    cycle(1'b0, 2'd0, '0, 4'h0, 1'b1);
    check("filled", 32'(dn_valid), 32'h9);
    cycle(1'b0, 2'd0, '0, 4'h0, 1'b0);
    check_cleared();
    for (int k = 0; k < 4; k++) cycle(1'b0, 2'd0, '0, 4'hf, 1'b1);
    check("no ghost transfers", dn_count, 32'h0);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 2000; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom),
            4'($urandom), 1'($urandom_range(0, 99) != 0));
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 2'd0, '0, 4'hf, 1'b1);
    for (int i = 0; i < 4; i++)
      check($sformatf("drained[%0d]", i), 32'(exp_q[i].size()), 32'h0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
